dmem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-port data memory (256 x 32-bit words, word-addressed by address[9:2], combinational read, write on posedge clk). Port 0 serves the CPU load/store stage. Port 1 serves a DMA/debug loader. The block serialises their requests, drives the memory's mem_write/mem_read/address/write_data inputs, registers read data, and flags misaligned or out-of-range addresses.

---
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-port 2**IDX_BITS x 32 data memory.
// One access per grant: IDLE -> ACCESS (memory cycle) -> DONE (ack pulse); requests wait while busy.
module dmem_arbiter #(
  parameter int IDX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        gnt, gnt_nxt;
  logic        grant_en;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        bad;
  logic        in_access;

  assign in_access = (state == ACCESS);
  assign busy      = (state != IDLE);
  assign bad       = (lat_addr[1:0] != 2'b00) || (lat_addr[31:IDX_BITS+2] != '0);

  // Memory strobes derive from state alone, so an async reset kills them before the next edge.
  assign mem_addr  = in_access ? lat_addr  : 32'h0;
  assign mem_wdata = in_access ? lat_wdata : 32'h0;
  assign mem_read  = in_access && !lat_we;
  assign mem_write = in_access && lat_we && !bad;

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    grant_en  = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie, the port that did not win last time gets the grant.
        if (req0 && (!req1 || last_grant)) begin
          grant_en  = 1'b1;
          gnt_nxt   = 1'b0;
          state_nxt = ACCESS;
        end else if (req1) begin
          grant_en  = 1'b1;
          gnt_nxt   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= 32'h0;
      rdata1     <= 32'h0;
      err0       <= 1'b0;
      err1       <= 1'b0;
    end else begin
      state <= state_nxt;
      ack0  <= in_access && !gnt;
      ack1  <= in_access && gnt;
      if (grant_en) begin
        gnt        <= gnt_nxt;
        last_grant <= gnt_nxt;
        lat_we     <= gnt_nxt ? we1    : we0;
        lat_addr   <= gnt_nxt ? addr1  : addr0;
        lat_wdata  <= gnt_nxt ? wdata1 : wdata0;
      end
      if (in_access) begin
        if (!gnt) begin
          rdata0 <= (lat_we || bad) ? 32'h0 : mem_rdata;
          err0   <= bad;
        end else begin
          rdata1 <= (lat_we || bad) ? 32'h0 : mem_rdata;
          err1   <= bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory attached.
module tb_dmem_arbiter;
  logic        clk;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.IDX_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preloaded with word i = 0xA0000000 + i on the first edge (during reset).
  logic [31:0] mem [0:255];
  logic        mem_ready = 1'b0;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Issue one request on a port, hold it until ack, observe for 8 cycles.
  task automatic run_single(input int port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int ack_cyc,
                            output logic [31:0] rd, output logic e, output int wr_cnt,
                            output logic [31:0] wr_addr, output int other_ack);
    ack_cyc = 0; rd = 32'hx; e = 1'bx; wr_cnt = 0; wr_addr = 32'h0; other_ack = 0;
    if (port == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (mem_write) begin
        wr_cnt++;
        wr_addr = mem_addr;
      end
      if (port == 0) begin
        if (ack1) other_ack++;
        if (ack0 && ack_cyc == 0) begin
          ack_cyc = i; rd = rdata0; e = err0; req0 = 1'b0;
        end
      end else begin
        if (ack0) other_ack++;
        if (ack1 && ack_cyc == 0) begin
          ack_cyc = i; rd = rdata1; e = err1; req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ack0, ack1, err0, err1, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got ack0/ack1/err0/err1/busy=%b want 00000", {ack0, ack1, err0, err1, busy});
    end
    checks++;
    if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
    end
    checks++;
    if ({mem_write, mem_read} !== 2'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: got wr=%b rd=%b addr=%h wdata=%h want all 0", mem_write, mem_read, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int ack_cyc, wr_cnt, other;
    logic [31:0] rd, wa;
    logic e;
    run_single(0, 1'b1, 32'h10, 32'hDEAD_BEEF, ack_cyc, rd, e, wr_cnt, wa, other);
    checks++;
    if (wr_cnt !== 1 || wa !== 32'h10) begin
      errors++;
      $display("FAIL wr_strobe: got %0d write cycles addr %h want 1 at 00000010", wr_cnt, wa);
    end
    checks++;
    if (ack_cyc !== 2) begin
      errors++;
      $display("FAIL wr_latency: got ack0 at cycle %0d want 2", ack_cyc);
    end
    run_single(0, 1'b0, 32'h10, 32'h0, ack_cyc, rd, e, wr_cnt, wa, other);
    checks++;
    if (ack_cyc !== 2 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL rd_back: got cyc=%0d rdata0=%h err0=%b want 2 deadbeef 0", ack_cyc, rd, e);
    end
    checks++;
    if (other !== 0 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL rd_side: got ack1 pulses=%0d writes=%0d want 0 0", other, wr_cnt);
    end
  endtask

  task automatic test_tie();
    int ports[$];
    int ticks[$];
    logic [31:0] first_rd0, first_rd1;
    int exp_port[6] = '{0, 1, 0, 1, 0, 1};
    int exp_tick[6] = '{2, 5, 8, 11, 14, 17};
    first_rd0 = 32'hx; first_rd1 = 32'hx;
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (ack0) begin
        ports.push_back(0); ticks.push_back(i);
        if (ports.size() == 1) first_rd0 = rdata0;
      end
      if (ack1) begin
        ports.push_back(1); ticks.push_back(i);
        if (ports.size() == 2) first_rd1 = rdata1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) tick();
    checks++;
    if (ports.size() != 6) begin
      errors++;
      $display("FAIL tie_count: got %0d acks want 6", ports.size());
    end
    for (int i = 0; i < 6 && i < ports.size(); i++) begin
      checks++;
      if (ports[i] !== exp_port[i] || ticks[i] !== exp_tick[i]) begin
        errors++;
        $display("FAIL tie_order[%0d]: got port %0d at %0d want port %0d at %0d", i, ports[i], ticks[i], exp_port[i], exp_tick[i]);
      end
    end
    checks++;
    if (first_rd0 !== 32'hA000_0000 || first_rd1 !== 32'hA000_0001) begin
      errors++;
      $display("FAIL tie_rdata: got %h/%h want a0000000/a0000001", first_rd0, first_rd1);
    end
  endtask

  task automatic test_misaligned();
    int ack_cyc, wr_cnt, other;
    logic [31:0] rd, wa;
    logic e;
    run_single(1, 1'b1, 32'h6, 32'hCAFE_F00D, ack_cyc, rd, e, wr_cnt, wa, other);
    checks++;
    if (ack_cyc !== 2 || e !== 1'b1 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL misaligned: got cyc=%0d err1=%b writes=%0d want 2 1 0", ack_cyc, e, wr_cnt);
    end
    run_single(1, 1'b0, 32'h4, 32'h0, ack_cyc, rd, e, wr_cnt, wa, other);
    checks++;
    if (rd !== 32'hA000_0001 || e !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_keep: got rdata1=%h err1=%b want a0000001 0", rd, e);
    end
  endtask

  task automatic test_oor();
    int ack_cyc, wr_cnt, other;
    logic [31:0] rd, wa;
    logic e;
    run_single(0, 1'b0, 32'h400, 32'h0, ack_cyc, rd, e, wr_cnt, wa, other);
    checks++;
    if (ack_cyc !== 2 || e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL out_of_range: got cyc=%0d err0=%b rdata0=%h want 2 1 0", ack_cyc, e, rd);
    end
  endtask

  task automatic test_reset_mid();
    int ack_cyc, wr_cnt, other, acks;
    logic [31:0] rd, wa;
    logic e;
    acks = 0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    tick();
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h20) begin
      errors++;
      $display("FAIL midrst_pre: got mem_write=%b addr=%h want 1 00000020", mem_write, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_drop: got mem_write=%b busy=%b want 0 0", mem_write, busy);
    end
    req0 = 1'b0;
    repeat (3) begin
      tick();
      if (ack0 || ack1) acks++;
    end
    rst_n = 1'b1;
    tick();
    if (ack0 || ack1) acks++;
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL midrst_ack: got %0d ack cycles want 0", acks);
    end
    run_single(0, 1'b0, 32'h20, 32'h0, ack_cyc, rd, e, wr_cnt, wa, other);
    checks++;
    if (rd !== 32'hA000_0008) begin
      errors++;
      $display("FAIL midrst_mem: got rdata0=%h want a0000008", rd);
    end
  endtask

  task automatic test_overlap();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL overlap_ack0: got ack0=%b ack1=%b rdata0=%h want 1 0 deadbeef", ack0, ack1, rdata0);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL overlap_idle: got busy=%b want 0", busy);
    end
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL overlap_grant1: got mem_read=%b addr=%h want 1 00000004", mem_read, mem_addr);
    end
    tick();
    checks++;
    if (ack1 !== 1'b1 || rdata1 !== 32'hA000_0001 || rdata0 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL overlap_ack1: got ack1=%b rdata1=%h rdata0=%h want 1 a0000001 deadbeef", ack1, rdata1, rdata0);
    end
    req1 = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
    test_reset();
    test_write_read();
    test_tie();
    test_misaligned();
    test_oor();
    test_reset_mid();
    test_overlap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
